// File: rtl/tnew_fwd_pipe.sv
// Producer-side Tnew/A3/write-flag pipeline (E, M, W) for the D-stage stall unit,
// plus the combinational bypass-mux selects for the D, E and M operand reads.
module tnew_fwd_pipe #(
  parameter int AW = 5,
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic [TW-1:0] tnew_d,
  input  logic [AW-1:0] a3_d,
  input  logic          w_d,
  input  logic [AW-1:0] rs_d,
  input  logic [AW-1:0] rt_d,
  output logic [TW-1:0] tnew_e,
  output logic [AW-1:0] a3_e,
  output logic          w_e,
  output logic [TW-1:0] tnew_m,
  output logic [AW-1:0] a3_m,
  output logic          w_m,
  output logic [AW-1:0] a3_w,
  output logic          w_w,
  output logic [1:0]    fwd_rs_d,
  output logic [1:0]    fwd_rt_d,
  output logic [1:0]    fwd_rs_e,
  output logic [1:0]    fwd_rt_e,
  output logic          fwd_rt_m
);

  logic [TW-1:0] tnew_e_q, tnew_e_d, tnew_m_q, tnew_m_d;
  logic [AW-1:0] a3_e_q, a3_e_d, rs_e_q, rs_e_d, rt_e_q, rt_e_d;
  logic [AW-1:0] a3_m_q, a3_m_d, rt_m_q, rt_m_d;
  logic [AW-1:0] a3_w_q, a3_w_d;
  logic          w_e_q, w_e_d, w_m_q, w_m_d, w_w_q, w_w_d;

  always_comb begin
    tnew_e_d = '0;
    a3_e_d   = '0;
    w_e_d    = 1'b0;
    rs_e_d   = '0;
    rt_e_d   = '0;
    if (!stall) begin
      tnew_e_d = tnew_d;
      a3_e_d   = a3_d;
      // $0 is hard-wired, so a write to it never produces a value worth bypassing
      w_e_d    = w_d & (a3_d != '0);
      rs_e_d   = rs_d;
      rt_e_d   = rt_d;
    end
    tnew_m_d = (tnew_e_q == '0) ? '0 : tnew_e_q - TW'(1);
    a3_m_d   = a3_e_q;
    w_m_d    = w_e_q;
    rt_m_d   = rt_e_q;
    a3_w_d   = a3_m_q;
    w_w_d    = w_m_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tnew_e_q <= '0;
      a3_e_q   <= '0;
      w_e_q    <= 1'b0;
      rs_e_q   <= '0;
      rt_e_q   <= '0;
      tnew_m_q <= '0;
      a3_m_q   <= '0;
      w_m_q    <= 1'b0;
      rt_m_q   <= '0;
      a3_w_q   <= '0;
      w_w_q    <= 1'b0;
    end else begin
      tnew_e_q <= tnew_e_d;
      a3_e_q   <= a3_e_d;
      w_e_q    <= w_e_d;
      rs_e_q   <= rs_e_d;
      rt_e_q   <= rt_e_d;
      tnew_m_q <= tnew_m_d;
      a3_m_q   <= a3_m_d;
      w_m_q    <= w_m_d;
      rt_m_q   <= rt_m_d;
      a3_w_q   <= a3_w_d;
      w_w_q    <= w_w_d;
    end
  end

  // A younger match that is not ready yet blocks older stages: the stall unit owns that case
  function automatic logic [1:0] sel_d(input logic [AW-1:0] sel);
    logic [1:0] r;
    r = 2'b00;
    if (sel != '0) begin
      if (w_e_q && (a3_e_q == sel))      r = (tnew_e_q == '0) ? 2'b01 : 2'b00;
      else if (w_m_q && (a3_m_q == sel)) r = (tnew_m_q == '0) ? 2'b10 : 2'b00;
      else if (w_w_q && (a3_w_q == sel)) r = 2'b11;
    end
    return r;
  endfunction

  function automatic logic [1:0] sel_e(input logic [AW-1:0] sel);
    logic [1:0] r;
    r = 2'b00;
    if (sel != '0) begin
      if (w_m_q && (a3_m_q == sel))      r = (tnew_m_q == '0) ? 2'b10 : 2'b00;
      else if (w_w_q && (a3_w_q == sel)) r = 2'b11;
    end
    return r;
  endfunction

  always_comb begin
    fwd_rs_d = sel_d(rs_d);
    fwd_rt_d = sel_d(rt_d);
    fwd_rs_e = sel_e(rs_e_q);
    fwd_rt_e = sel_e(rt_e_q);
    fwd_rt_m = w_w_q & (a3_w_q == rt_m_q) & (rt_m_q != '0);
  end

  assign tnew_e = tnew_e_q;
  assign a3_e   = a3_e_q;
  assign w_e    = w_e_q;
  assign tnew_m = tnew_m_q;
  assign a3_m   = a3_m_q;
  assign w_m    = w_m_q;
  assign a3_w   = a3_w_q;
  assign w_w    = w_w_q;

endmodule

// File: tb/tb_tnew_fwd_pipe.sv
// Bench for tnew_fwd_pipe: directed pipeline scenarios then random traffic, checked
// every cycle against an instruction-history model through an expected-value queue.
module tb_tnew_fwd_pipe;

  localparam int W = 31;

  logic       clk;
  logic       reset;
  logic       stall;
  logic [1:0] tnew_d;
  logic [4:0] a3_d;
  logic       w_d;
  logic [4:0] rs_d;
  logic [4:0] rt_d;
  logic [1:0] tnew_e, tnew_m;
  logic [4:0] a3_e, a3_m, a3_w;
  logic       w_e, w_m, w_w;
  logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic       fwd_rt_m;

  tnew_fwd_pipe dut (
    .clk(clk), .reset(reset), .stall(stall),
    .tnew_d(tnew_d), .a3_d(a3_d), .w_d(w_d), .rs_d(rs_d), .rt_d(rt_d),
    .tnew_e(tnew_e), .a3_e(a3_e), .w_e(w_e),
    .tnew_m(tnew_m), .a3_m(a3_m), .w_m(w_m),
    .a3_w(a3_w), .w_w(w_w),
    .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0] tnew;
    logic [4:0] a3;
    logic       w;
    logic [4:0] rs;
    logic [4:0] rt;
  } ent_t;

  // Last three instructions issued into E, oldest first: [0]=W, [1]=M, [2]=E
  ent_t hist[$];
  bit   model_valid = 0;
  int   cyc = 0;

  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           checks = 0;
  int           errors = 0;

  function automatic int aged(input ent_t e, input int age);
    int t;
    t = int'(e.tnew) - age;
    return (t < 0) ? 0 : t;
  endfunction

  // Walk stages from 'first' (0=E,1=M,2=W) toward older ones; the youngest stage
  // that will write 'sel' decides. W is always ready.
  function automatic logic [1:0] pick(input logic [4:0] sel, input int first);
    ent_t e;
    if (sel == 5'd0) return 2'b00;
    for (int s = first; s < 3; s++) begin
      e = hist[2 - s];
      if (e.w && e.a3 == sel) begin
        if (s == 2 || aged(e, s) == 0) return 2'(s + 1);
        return 2'b00;
      end
    end
    return 2'b00;
  endfunction

  function automatic logic [W-1:0] expected();
    ent_t e, m, wv;
    logic [1:0] tm;
    e  = hist[2];
    m  = hist[1];
    wv = hist[0];
    tm = 2'(aged(m, 1));
    return {e.tnew, e.a3, e.w, tm, m.a3, m.w, wv.a3, wv.w,
            pick(rs_d, 0), pick(rt_d, 0), pick(e.rs, 1), pick(e.rt, 1),
            (pick(m.rt, 2) != 2'b00)};
  endfunction

  task automatic model_step(input logic rst, input logic stl);
    ent_t n;
    if (!rst) begin
      hist.delete();
      repeat (3) hist.push_back('0);
      model_valid = 1;
    end else begin
      n = '0;
      if (!stl) begin
        n.tnew = tnew_d;
        n.a3   = a3_d;
        n.w    = w_d && (a3_d != 5'd0);
        n.rs   = rs_d;
        n.rt   = rt_d;
      end
      hist.push_back(n);
      void'(hist.pop_front());
    end
  endtask

  // ---------------- driver ----------------
  task automatic cyc_drive(input logic rst, input logic stl, input logic [1:0] tn,
                           input logic [4:0] a3, input logic wr,
                           input logic [4:0] rs, input logic [4:0] rt);
    reset  = rst;
    stall  = stl;
    tnew_d = tn;
    a3_d   = a3;
    w_d    = wr;
    rs_d   = rs;
    rt_d   = rt;
    if (model_valid) begin
      exp_q.push_back(expected());
      exp_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    model_step(rst, stl);
    cyc++;
    #1;
  endtask

  task automatic nop();
    cyc_drive(1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 5'd0, 5'd0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [W-1:0] got, exp_v;
  int           exp_c;
  assign got = {tnew_e, a3_e, w_e, tnew_m, a3_m, w_m, a3_w, w_w,
                fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m};

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        exp_c = exp_cyc_q.pop_front();
        checks++;
        if (got !== exp_v) begin
          errors++;
          $display("FAIL obs_cycle%0d: got %h exp %h (fields te,a3e,we,tm,a3m,wm,a3w,ww,frsd,frtd,frse,frte,frtm)",
                   exp_c, got, exp_v);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    hist.delete();
    repeat (3) hist.push_back('0);

    // Reset held two cycles with a live writer on D
    cyc_drive(1'b0, 1'b0, 2'd1, 5'd5, 1'b1, 5'd5, 5'd5);
    cyc_drive(1'b0, 1'b0, 2'd1, 5'd5, 1'b1, 5'd5, 5'd5);
    cyc_drive(1'b1, 1'b0, 2'd1, 5'd5, 1'b1, 5'd0, 5'd0);
    nop(); nop(); nop();

    // ALU chain: addu $3, then two readers of $3
    cyc_drive(1'b1, 1'b0, 2'd1, 5'd3, 1'b1, 5'd1, 5'd2);
    cyc_drive(1'b1, 1'b0, 2'd1, 5'd9, 1'b1, 5'd3, 5'd0);
    cyc_drive(1'b1, 1'b0, 2'd1, 5'd10, 1'b1, 5'd3, 5'd0);
    nop(); nop(); nop();

    // Load-use: lw $4, beq rs=$4 stalled for two cycles
    cyc_drive(1'b1, 1'b0, 2'd2, 5'd4, 1'b1, 5'd1, 5'd0);
    cyc_drive(1'b1, 1'b1, 2'd0, 5'd0, 1'b0, 5'd4, 5'd0);
    cyc_drive(1'b1, 1'b1, 2'd0, 5'd0, 1'b0, 5'd4, 5'd0);
    cyc_drive(1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 5'd4, 5'd0);
    nop(); nop(); nop();

    // $0 suppression
    cyc_drive(1'b1, 1'b0, 2'd1, 5'd0, 1'b1, 5'd0, 5'd0);
    cyc_drive(1'b1, 1'b0, 2'd1, 5'd5, 1'b1, 5'd0, 5'd0);
    nop(); nop(); nop();

    // Priority: addu $31 then jal ($31, tnew 0), reader of $31 in D
    cyc_drive(1'b1, 1'b0, 2'd1, 5'd31, 1'b1, 5'd0, 5'd0);
    cyc_drive(1'b1, 1'b0, 2'd0, 5'd31, 1'b1, 5'd0, 5'd0);
    cyc_drive(1'b1, 1'b0, 2'd1, 5'd8, 1'b1, 5'd31, 5'd31);
    nop(); nop(); nop();

    // sw data: lw $6 / sw rt=6, then lw $7 / sw rt=6
    cyc_drive(1'b1, 1'b0, 2'd2, 5'd6, 1'b1, 5'd1, 5'd0);
    cyc_drive(1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 5'd1, 5'd6);
    nop(); nop(); nop();
    cyc_drive(1'b1, 1'b0, 2'd2, 5'd7, 1'b1, 5'd1, 5'd0);
    cyc_drive(1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 5'd1, 5'd6);
    nop(); nop(); nop();

    // Mid-stream reset discards in-flight writers
    cyc_drive(1'b1, 1'b0, 2'd0, 5'd2, 1'b1, 5'd0, 5'd0);
    cyc_drive(1'b1, 1'b0, 2'd0, 5'd3, 1'b1, 5'd2, 5'd0);
    cyc_drive(1'b0, 1'b0, 2'd0, 5'd4, 1'b1, 5'd2, 5'd3);
    cyc_drive(1'b1, 1'b0, 2'd0, 5'd0, 1'b0, 5'd2, 5'd3);
    nop();

    // Random traffic over a small register set to provoke many hits
    for (int i = 0; i < 400; i++) begin
      logic [4:0] regs [5];
      logic       r, s, wr;
      logic [1:0] tn;
      regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd2; regs[3] = 5'd3; regs[4] = 5'd31;
      r  = ($urandom_range(0, 39) != 0);
      s  = ($urandom_range(0, 3) == 0);
      wr = ($urandom_range(0, 3) != 0);
      tn = 2'($urandom_range(0, 3));
      cyc_drive(r, s, tn, regs[$urandom_range(0, 4)], wr,
                regs[$urandom_range(0, 4)], regs[$urandom_range(0, 4)]);
    end
    nop();

    // Monitor must have drained every expectation
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
